operand_fetch_stage: RTL and testbench

//  Registered operand-fetch pipeline stage between decode and execute. Reads
//  the architectural register file, masks operands to instruction size, and

---
 rtl/operand_fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: reads the register file, size-masks operands and keeps a pending-write scoreboard.
// Latency: 1 cycle from accept to out_valid. Optional feature macro: OF_WB_BYPASS_EN (same-cycle writeback forwarding).
// Backpressure: in_ready drops on a RAW/WAW hazard, on flush/reset, or when the held output is not consumed.
module operand_fetch_stage #(
    parameter int NREGS = 16,
    parameter int XLEN  = 64,
    parameter int CNTW  = 32,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_nop,
    input  logic [7:0]             in_opcode,
    input  logic [63:0]            in_curr,
    input  logic [1:0]             in_srcty,
    input  logic [XLEN-1:0]        in_srcval,
    input  logic [RW-1:0]          in_dstreg,
    input  logic                   in_dst_we,
    input  logic [1:0]             in_size,
    input  logic [NREGS*XLEN-1:0]  regfile_flat,
    input  logic                   wb_valid,
    input  logic [RW-1:0]          wb_reg,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_nop,
    output logic [7:0]             out_opcode,
    output logic [63:0]            out_curr,
    output logic [RW-1:0]          out_dstreg,
    output logic                   out_dst_we,
    output logic [1:0]             out_size,
    output logic [XLEN-1:0]        out_oper1,
    output logic [XLEN-1:0]        out_oper2,
    output logic [CNTW-1:0]        stall_cycles
);

    localparam logic [1:0] SRC_REG = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    // Keep only the low 8/16/32 bits; size code 3 passes the whole word.
    function automatic logic [XLEN-1:0] size_mask(input logic [XLEN-1:0] v, input logic [1:0] sz);
        logic [XLEN-1:0] m;
        m = '0;
        case (sz)
            2'd0:    m[7:0]  = v[7:0];
            2'd1:    m[15:0] = v[15:0];
            2'd2:    m[31:0] = v[31:0];
            default: m       = v;
        endcase
        return m;
    endfunction

    logic [XLEN-1:0] rf [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CNTW-1:0]  stall_q, stall_d;

    logic             out_valid_q, out_valid_d;
    logic             out_nop_q, out_nop_d;
    logic [7:0]       out_opcode_q, out_opcode_d;
    logic [63:0]      out_curr_q, out_curr_d;
    logic [RW-1:0]    out_dstreg_q, out_dstreg_d;
    logic             out_dst_we_q, out_dst_we_d;
    logic [1:0]       out_size_q, out_size_d;
    logic [XLEN-1:0]  out_oper1_q, out_oper1_d;
    logic [XLEN-1:0]  out_oper2_q, out_oper2_d;

    logic [RW-1:0]    src_idx;
    logic             wb_hit_dst, wb_hit_src;
    logic             dst_busy, src_busy;
    logic [XLEN-1:0]  dst_raw, src_raw;
    logic [XLEN-1:0]  oper1_val, oper2_val;
    logic             hazard, accept;

    // Unpack the flat register file bus into one word per register.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf[i] = regfile_flat[i*XLEN +: XLEN];
        end
    end

    // Hazard detection and operand selection, with optional writeback forwarding.
    always_comb begin
        src_idx    = in_srcval[RW-1:0];
        wb_hit_dst = wb_valid && (wb_reg == in_dstreg);
        wb_hit_src = wb_valid && (wb_reg == src_idx);
`ifdef OF_WB_BYPASS_EN
        // A register being written back this cycle is ready: forward wb_data.
        dst_busy = busy_q[in_dstreg] && !wb_hit_dst;
        src_busy = busy_q[src_idx]   && !wb_hit_src;
        dst_raw  = wb_hit_dst ? wb_data : rf[in_dstreg];
        src_raw  = wb_hit_src ? wb_data : rf[src_idx];
`else
        // Without forwarding the reader waits until the write has landed in the file.
        dst_busy = busy_q[in_dstreg];
        src_busy = busy_q[src_idx];
        dst_raw  = rf[in_dstreg];
        src_raw  = rf[src_idx];
`endif
        hazard = in_valid && !in_nop && (dst_busy || ((in_srcty == SRC_REG) && src_busy));

        oper1_val = size_mask(dst_raw, in_size);
        case (in_srcty)
            SRC_REG: oper2_val = size_mask(src_raw, in_size);
            SRC_MEM: oper2_val = in_srcval;
            SRC_IMM: oper2_val = size_mask(in_srcval, in_size);
            default: oper2_val = '0;
        endcase

        in_ready = !reset && !flush && !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Next state for the output register, scoreboard and stall counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_nop_d    = out_nop_q;
        out_opcode_d = out_opcode_q;
        out_curr_d   = out_curr_q;
        out_dstreg_d = out_dstreg_q;
        out_dst_we_d = out_dst_we_q;
        out_size_d   = out_size_q;
        out_oper1_d  = out_oper1_q;
        out_oper2_d  = out_oper2_q;
        busy_d       = busy_q;
        stall_d      = stall_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_nop_d    = in_nop;
            out_opcode_d = in_opcode;
            out_curr_d   = in_curr;
            out_dstreg_d = in_dstreg;
            out_size_d   = in_size;
            out_dst_we_d = in_dst_we && !in_nop;
            out_oper1_d  = in_nop ? '0 : oper1_val;
            out_oper2_d  = in_nop ? '0 : oper2_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear on writeback first so a same-cycle new writer keeps the register busy.
        if (wb_valid) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (accept && !in_nop && in_dst_we) begin
            busy_d[in_dstreg] = 1'b1;
        end

        if (flush) begin
            out_valid_d = 1'b0;
            busy_d      = '0;
        end

        if (hazard && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_nop_q    <= 1'b0;
            out_opcode_q <= '0;
            out_curr_q   <= '0;
            out_dstreg_q <= '0;
            out_dst_we_q <= 1'b0;
            out_size_q   <= '0;
            out_oper1_q  <= '0;
            out_oper2_q  <= '0;
            busy_q       <= '0;
            stall_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_nop_q    <= out_nop_d;
            out_opcode_q <= out_opcode_d;
            out_curr_q   <= out_curr_d;
            out_dstreg_q <= out_dstreg_d;
            out_dst_we_q <= out_dst_we_d;
            out_size_q   <= out_size_d;
            out_oper1_q  <= out_oper1_d;
            out_oper2_q  <= out_oper2_d;
            busy_q       <= busy_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_nop      = out_nop_q;
    assign out_opcode   = out_opcode_q;
    assign out_curr     = out_curr_q;
    assign out_dstreg   = out_dstreg_q;
    assign out_dst_we   = out_dst_we_q;
    assign out_size     = out_size_q;
    assign out_oper1    = out_oper1_q;
    assign out_oper2    = out_oper2_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios then random traffic against a reference model.
// Counter width is reduced so that saturation is reached during the random phase.
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
module tb_operand_fetch_stage;
    localparam int NREGS = 16;
    localparam int XLEN  = 64;
    localparam int CNTW  = 8;
    localparam int SMAX  = (1 << CNTW) - 1;
`ifdef OF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk;
    logic                  reset, flush;
    logic                  in_valid, in_ready, in_nop, in_dst_we;
    logic [7:0]            in_opcode;
    logic [63:0]           in_curr;
    logic [1:0]            in_srcty, in_size;
    logic [XLEN-1:0]       in_srcval;
    logic [3:0]            in_dstreg;
    logic [NREGS*XLEN-1:0] regfile_flat;
    logic                  wb_valid;
    logic [3:0]            wb_reg;
    logic [XLEN-1:0]       wb_data;
    logic                  out_valid, out_ready, out_nop, out_dst_we;
    logic [7:0]            out_opcode;
    logic [63:0]           out_curr;
    logic [3:0]            out_dstreg;
    logic [1:0]            out_size;
    logic [XLEN-1:0]       out_oper1, out_oper2;
    logic [CNTW-1:0]       stall_cycles;

    operand_fetch_stage #(.NREGS(NREGS), .XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
        .in_opcode(in_opcode), .in_curr(in_curr), .in_srcty(in_srcty),
        .in_srcval(in_srcval), .in_dstreg(in_dstreg), .in_dst_we(in_dst_we),
        .in_size(in_size), .regfile_flat(regfile_flat),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_nop(out_nop),
        .out_opcode(out_opcode), .out_curr(out_curr), .out_dstreg(out_dstreg),
        .out_dst_we(out_dst_we), .out_size(out_size),
        .out_oper1(out_oper1), .out_oper2(out_oper2), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural register file owned by the bench.
    logic [XLEN-1:0] rf [NREGS];
    always_comb begin
        for (int i = 0; i < NREGS; i++) regfile_flat[i*XLEN +: XLEN] = rf[i];
    end

    // Reference model state.
    bit              pend [NREGS];
    bit              m_valid, m_nop, m_we;
    logic [7:0]      m_opcode;
    logic [63:0]     m_curr;
    logic [3:0]      m_dst;
    logic [1:0]      m_size;
    logic [XLEN-1:0] m_op1, m_op2;
    int              m_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [XLEN-1:0] mask(input logic [XLEN-1:0] v, input logic [1:0] sz);
        int bits;
        bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : (sz == 2'd2) ? 32 : 64;
        if (bits == 64) return v;
        return v & ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic bit wb_hits(input logic [3:0] r);
        return wb_valid && (wb_reg == r);
    endfunction

    function automatic bit eff_busy(input logic [3:0] r);
        return pend[r] && !(BYP && wb_hits(r));
    endfunction

    function automatic logic [XLEN-1:0] rd(input logic [3:0] r);
        return (BYP && wb_hits(r)) ? wb_data : rf[r];
    endfunction

    // One clock: entered on a falling edge with inputs set, returns on the next falling edge.
    task automatic step(output logic acc);
        logic hz, rdy;
        logic [XLEN-1:0] o1, o2;
        logic [3:0] src;
        #1;
        src = in_srcval[3:0];
        hz  = in_valid && !in_nop && (eff_busy(in_dstreg) || (in_srcty == 2'd0 && eff_busy(src)));
        rdy = !reset && !flush && !hz && (!m_valid || out_ready);
        acc = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        o1 = mask(rd(in_dstreg), in_size);
        case (in_srcty)
            2'd0:    o2 = mask(rd(src), in_size);
            2'd1:    o2 = in_srcval;
            default: o2 = mask(in_srcval, in_size);
        endcase
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_nop = 0; m_we = 0; m_opcode = '0; m_curr = '0;
            m_dst = '0; m_size = '0; m_op1 = '0; m_op2 = '0; m_stall = 0;
            foreach (pend[i]) pend[i] = 0;
        end else begin
            if (hz && m_stall < SMAX) m_stall++;
            if (flush) begin
                m_valid = 0;
                foreach (pend[i]) pend[i] = 0;
            end else begin
                if (acc) begin
                    m_valid = 1; m_nop = in_nop; m_opcode = in_opcode; m_curr = in_curr;
                    m_dst = in_dstreg; m_size = in_size; m_we = in_dst_we && !in_nop;
                    m_op1 = in_nop ? '0 : o1;
                    m_op2 = in_nop ? '0 : o2;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                if (wb_valid) pend[wb_reg] = 0;
                if (acc && !in_nop && in_dst_we) pend[in_dstreg] = 1;
            end
        end
        if (wb_valid) rf[wb_reg] = wb_data;
        chk("out_valid", out_valid, m_valid);
        chk("out_nop", out_nop, m_nop);
        chk("out_opcode", out_opcode, m_opcode);
        chk("out_curr", out_curr, m_curr);
        chk("out_dstreg", out_dstreg, m_dst);
        chk("out_dst_we", out_dst_we, m_we);
        chk("out_size", out_size, m_size);
        chk("out_oper1", out_oper1, m_op1);
        chk("out_oper2", out_oper2, m_op2);
        chk("stall_cycles", stall_cycles, m_stall);
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 0; flush = 0; in_valid = 0; in_nop = 0; in_opcode = '0; in_curr = '0;
        in_srcty = 2'd2; in_srcval = '0; in_dstreg = '0; in_dst_we = 0; in_size = 2'd3;
        wb_valid = 0; wb_reg = '0; wb_data = '0; out_ready = 1;
    endtask

    task automatic set_entry(input logic [7:0] op, input logic [1:0] sty, input logic [63:0] sval,
                             input logic [3:0] dst, input logic we, input logic [1:0] sz);
        in_valid = 1; in_nop = 0; in_opcode = op; in_curr = {56'h0, op} << 2;
        in_srcty = sty; in_srcval = sval; in_dstreg = dst; in_dst_we = we; in_size = sz;
    endtask

    task automatic do_reset();
        logic a;
        set_idle();
        reset = 1;
        step(a);
        reset = 0;
    endtask

    logic a;
    int   s0, n;
    int   pq [$];

    initial begin
        foreach (rf[i]) rf[i] = {$urandom, $urandom};
        foreach (pend[i]) pend[i] = 0;
        m_valid = 0; m_nop = 0; m_we = 0; m_opcode = '0; m_curr = '0;
        m_dst = '0; m_size = '0; m_op1 = '0; m_op2 = '0; m_stall = 0;
        set_idle();
        reset = 1;
        @(negedge clk);
        step(a);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_stall", stall_cycles, 0);
        reset = 0;

        // 1: register add, full size.
        rf[0] = 64'd5; rf[1] = 64'd7;
        set_entry(8'h01, 2'd0, 64'd1, 4'd0, 1'b1, 2'd3);
        step(a);
        chk("t1_valid", out_valid, 1);
        chk("t1_oper1", out_oper1, 64'd5);
        chk("t1_oper2", out_oper2, 64'd7);
        set_entry(8'h02, 2'd2, 64'd3, 4'd0, 1'b0, 2'd3);
        #1;
        chk("t1_busy0_stalls", in_ready, 0);
        step(a);

        // 2: byte-sized immediate.
        do_reset();
        rf[3] = 64'hFFFF_FFFF_FFFF_FFAB;
        set_entry(8'h03, 2'd2, 64'h1234, 4'd3, 1'b0, 2'd0);
        step(a);
        chk("t2_oper1", out_oper1, 64'hAB);
        chk("t2_oper2", out_oper2, 64'h34);

        // 3: RAW hazard resolved by writeback.
        do_reset();
        rf[2] = 64'h55;
        set_entry(8'h10, 2'd2, 64'd7, 4'd2, 1'b1, 2'd3);
        step(a);
        s0 = m_stall;
        set_entry(8'h11, 2'd0, 64'd2, 4'd5, 1'b1, 2'd3);
        repeat (3) step(a);
        wb_valid = 1; wb_reg = 4'd2; wb_data = 64'd9;
        step(a);
        wb_valid = 0;
        n = 0;
        while (!a && n < 4) begin
            step(a);
            n++;
        end
        if (!a) chk("t3_accept_timeout", 0, 1);
        in_valid = 0;
        chk("t3_oper2", out_oper2, 64'd9);
        chk("t3_stall_delta", stall_cycles, s0 + 3 + (BYP ? 0 : 1));
        step(a);

        // 4: output backpressure holds the entry.
        do_reset();
        set_entry(8'h44, 2'd2, 64'd1, 4'd6, 1'b0, 2'd3);
        step(a);
        out_ready = 0;
        set_entry(8'h55, 2'd2, 64'd2, 4'd7, 1'b0, 2'd3);
        s0 = m_stall;
        repeat (3) begin
            #1;
            chk("t4_in_ready", in_ready, 0);
            step(a);
            chk("t4_opcode_held", out_opcode, 8'h44);
            chk("t4_valid_held", out_valid, 1);
        end
        chk("t4_stall_kept", stall_cycles, s0);
        out_ready = 1;
        step(a);
        chk("t4_next_opcode", out_opcode, 8'h55);

        // 5: memory address is never masked.
        do_reset();
        set_entry(8'h05, 2'd1, 64'hDEAD_BEEF_0000_1000, 4'd8, 1'b0, 2'd1);
        step(a);
        chk("t5_oper2", out_oper2, 64'hDEAD_BEEF_0000_1000);

        // 6: flush drops the output and the scoreboard.
        do_reset();
        set_entry(8'h06, 2'd2, 64'd1, 4'd4, 1'b1, 2'd3);
        out_ready = 0;
        step(a);
        set_idle();
        out_ready = 0;
        flush = 1;
        step(a);
        flush = 0;
        chk("t6_valid", out_valid, 0);
        set_entry(8'h07, 2'd0, 64'd4, 4'd9, 1'b0, 2'd3);
        #1;
        chk("t6_reader_ready", in_ready, 1);
        step(a);
        chk("t6_reader_oper2", out_oper2, rf[4]);

        // Random traffic.
        set_idle();
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            flush     = !reset && ($urandom_range(0, 59) == 0);
            in_valid  = !flush && ($urandom_range(0, 3) != 0);
            in_nop    = ($urandom_range(0, 7) == 0);
            in_opcode = 8'($urandom);
            in_curr   = {$urandom, $urandom};
            in_srcty  = 2'($urandom_range(0, 2));
            in_srcval = {$urandom, $urandom};
            in_dstreg = 4'($urandom_range(0, 15));
            in_dst_we = ($urandom_range(0, 1) == 1);
            in_size   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            pq.delete();
            for (int r = 0; r < NREGS; r++) if (pend[r]) pq.push_back(r);
            wb_valid = (pq.size() > 0) && ($urandom_range(0, 1) == 1);
            wb_reg   = wb_valid ? 4'(pq[$urandom_range(0, pq.size() - 1)]) : 4'd0;
            wb_data  = {$urandom, $urandom};
            step(a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
